// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter and sequencer for the shared 4x4-bit register bank.
// Ports: clk, rst; per requester req/we/addr/wdata in, gnt/ack out; rdata, busy.
module reg_bank_arbiter #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             we0,
  input  logic [AW-1:0]    addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             gnt0,
  output logic             ack0,
  input  logic             req1,
  input  logic             we1,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt1,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ACK
  } state_t;

  state_t state;
  state_t state_nx;

  logic             prio;
  logic             sel;
  logic             s_we;
  logic [AW-1:0]    s_addr;
  logic [WIDTH-1:0] s_wdata;
  logic [WIDTH-1:0] mem [DEPTH];

  logic take;
  logic win;

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    win      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          take     = 1'b1;
          // tie goes to the requester named by prio
          win      = (req0 && req1) ? prio : req1;
          state_nx = GRANT;
        end
      end
      GRANT:   state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      prio    <= 1'b0;
      sel     <= 1'b0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        sel     <= win;
        s_we    <= win ? we1    : we0;
        s_addr  <= win ? addr1  : addr0;
        s_wdata <= win ? wdata1 : wdata0;
      end
      if (state == ACK) begin
        prio <= ~sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else if (state == GRANT) begin
      if (s_we) begin
        mem[s_addr] <= s_wdata;
      end else begin
        rdata <= mem[s_addr];
      end
    end
  end

  assign busy = (state != IDLE);
  assign gnt0 = busy && !sel;
  assign gnt1 = busy && sel;
  assign ack0 = (state == ACK) && !sel;
  assign ack1 = (state == ACK) && sel;

endmodule
